// File: rtl/display_mux_pkg.sv
// Shared types for the six-digit multiplexed clock display driver.
package display_mux_pkg;

  localparam int N_DIGITS = 6;

  typedef enum logic {
    GUARD = 1'b0,
    ON    = 1'b1
  } slot_state_e;

  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t LAST_IDX = digit_idx_t'(N_DIGITS - 1);

  function automatic logic [3:0] frame_nibble(input logic [4*N_DIGITS-1:0] frame,
                                              input digit_idx_t idx);
    logic [3:0] nib;
    nib = frame[3:0];
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == digit_idx_t'(i)) nib = frame[4*i +: 4];
    end
    return nib;
  endfunction

endpackage

// File: rtl/display_mux_if.sv
// Display bus: digit/control inputs, shared decoder loop and panel drive outputs.
interface display_mux_if;
  import display_mux_pkg::*;

  logic [4*N_DIGITS-1:0] mux_digits_in;
  logic                  mux_blank_lead_in;
  logic [N_DIGITS-1:0]   mux_blink_mask_in;
  logic [3:0]            mux_bcd_out;
  logic [6:0]            mux_seg_in;
  logic [6:0]            mux_seg_out;
  logic [N_DIGITS-1:0]   mux_an_out;
  logic                  mux_dp_out;

  modport master (
    output mux_digits_in, mux_blank_lead_in, mux_blink_mask_in, mux_seg_in,
    input  mux_bcd_out, mux_seg_out, mux_an_out, mux_dp_out
  );

  modport slave (
    input  mux_digits_in, mux_blank_lead_in, mux_blink_mask_in, mux_seg_in,
    output mux_bcd_out, mux_seg_out, mux_an_out, mux_dp_out
  );

endinterface

// File: rtl/display_mux_tick_div.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count as tick.
module tick_div #(
  parameter int DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_mux.sv
// Six-digit multiplexed 7-segment driver with anti-ghost guard cycle and frame latch.
// Optional blink support is compiled in with DISPLAY_MUX_BLINK_EN.
module display_mux
  import display_mux_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 83
) (
  input  logic         mux_clk,
  input  logic         mux_rst,
  display_mux_if.slave bus
);

  logic                  tick, wrap;
  digit_idx_t            idx_q, idx_d;
  slot_state_e           state_q, state_d;
  logic [4*N_DIGITS-1:0] frame_q, frame_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  phase_on, mask_blank, lead_blank, blanked;

  tick_div #(.DIV(SCAN_DIV)) u_div (
    .clk_i (mux_clk),
    .rst_i (mux_rst),
    .tick  (tick)
  );

  assign wrap = tick && (idx_q == LAST_IDX);

  always_comb begin
    idx_d   = idx_q;
    state_d = state_q;
    frame_d = frame_q;
    bcd_d   = bcd_q;
    if (tick) begin
      state_d = GUARD;
      if (wrap) begin
        idx_d   = '0;
        frame_d = bus.mux_digits_in;
      end else begin
        idx_d = idx_q + 3'd1;
      end
      bcd_d = frame_nibble(frame_d, idx_d);
    end else if (state_q == GUARD) begin
      state_d = ON;
    end
    an_d = (state_d == ON) ? ({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_d) : '0;
  end

  always_ff @(posedge mux_clk or posedge mux_rst) begin
    if (mux_rst) begin
      idx_q   <= '0;
      state_q <= GUARD;
      frame_q <= '0;
      bcd_q   <= '0;
      an_q    <= '0;
    end else begin
      idx_q   <= idx_d;
      state_q <= state_d;
      frame_q <= frame_d;
      bcd_q   <= bcd_d;
      an_q    <= an_d;
    end
  end

`ifdef DISPLAY_MUX_BLINK_EN
  localparam int FCW = $clog2(BLINK_FRAMES + 1);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(BLINK_FRAMES - 1);

  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           phase_q, phase_d;

  // Phase flips once every BLINK_FRAMES completed frames.
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (wrap) begin
      if (fcnt_q == FRAME_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge mux_clk or posedge mux_rst) begin
    if (mux_rst) begin
      fcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_on   = phase_q;
  assign mask_blank = bus.mux_blink_mask_in[idx_q] && !phase_q;
`else
  logic unused_blink;
  assign unused_blink = ^{bus.mux_blink_mask_in, (BLINK_FRAMES > 0)};
  assign phase_on     = 1'b1;
  assign mask_blank   = 1'b0;
`endif

  assign lead_blank = (idx_q == LAST_IDX) && (bcd_q == 4'd0) && bus.mux_blank_lead_in;
  assign blanked    = lead_blank || mask_blank;

  assign bus.mux_bcd_out = bcd_q;
  assign bus.mux_an_out  = an_q;
  assign bus.mux_seg_out = ((state_q == ON) && !blanked) ? bus.mux_seg_in : 7'd0;
  assign bus.mux_dp_out  = (state_q == ON) && ((idx_q == 3'd2) || (idx_q == 3'd4)) && phase_on;

endmodule

// File: tb/tb_display_mux.sv
// Scoreboard bench for display_mux at SCAN_DIV=4, BLINK_FRAMES=2.
module tb_display_mux;

  localparam int SDIV    = 4;
  localparam int BLINK   = 2;
  localparam int N_SLOTS = 84;

  typedef struct packed {
    logic [3:0] bcd;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  display_mux_if bus ();

  exp_t  sb_q[$];
  exp_t  cur;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_popped = 0;
  int    on_cnt = 0;
  logic  mon_en = 1'b0;
  logic [5:0]  prev_an = 6'd0;
  logic [23:0] exp_frame;

  display_mux #(.SCAN_DIV(SDIV), .BLINK_FRAMES(BLINK)) dut (
    .mux_clk (clk),
    .mux_rst (rst),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  assign bus.mux_seg_in = dec7(bus.mux_bcd_out);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_slot(input int idx, input int f);
    exp_t e;
    logic [3:0] nib;
    logic ph, blk;
    nib = 4'(exp_frame >> (4 * idx));
    ph  = 1'b1;
`ifdef DISPLAY_MUX_BLINK_EN
    ph  = ((f / BLINK) % 2) == 0;
`endif
    blk = (idx == 5) && (nib == 4'd0) && bus.mux_blank_lead_in;
`ifdef DISPLAY_MUX_BLINK_EN
    blk = blk || (bus.mux_blink_mask_in[idx] && !ph);
`endif
    e.bcd = nib;
    e.an  = 6'(1 << idx);
    e.seg = blk ? 7'd0 : dec7(nib);
    e.dp  = ((idx == 2) || (idx == 4)) && ph;
    sb_q.push_back(e);
  endtask

  // Monitor: one scoreboard entry per ON window, guard cycles must be dark.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (bus.mux_an_out == 6'd0) begin
        check("guard_seg", 32'(bus.mux_seg_out), 32'h0);
        check("guard_dp", 32'(bus.mux_dp_out), 32'h0);
        if (prev_an != 6'd0) check("on_len", 32'(on_cnt), 32'(SDIV - 1));
        on_cnt = 0;
      end else begin
        if (prev_an == 6'd0) begin
          check("sb_level", 32'(sb_q.size() != 0), 32'h1);
          if (sb_q.size() != 0) begin
            cur = sb_q.pop_front();
            n_popped++;
          end
        end
        on_cnt++;
        check("an", 32'(bus.mux_an_out), 32'(cur.an));
        check("bcd", 32'(bus.mux_bcd_out), 32'(cur.bcd));
        check("seg", 32'(bus.mux_seg_out), 32'(cur.seg));
        check("dp", 32'(bus.mux_dp_out), 32'(cur.dp));
      end
      prev_an = bus.mux_an_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, f;
    rst = 1'b1;
    bus.mux_digits_in     = 24'h123456;
    bus.mux_blank_lead_in = 1'b0;
    bus.mux_blink_mask_in = 6'b000000;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Run into frame 1, index 2, mid-ON, then hit reset between edges.
    repeat (34) @(posedge clk);
    #3;
    check("pre_an", 32'(bus.mux_an_out), 32'h04);
    check("pre_bcd", 32'(bus.mux_bcd_out), 32'h4);
    check("pre_dp", 32'(bus.mux_dp_out), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_bcd", 32'(bus.mux_bcd_out), 32'h0);
    check("rst_an", 32'(bus.mux_an_out), 32'h0);
    check("rst_seg", 32'(bus.mux_seg_out), 32'h0);
    check("rst_dp", 32'(bus.mux_dp_out), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_an", 32'(bus.mux_an_out), 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    check("rel_an", 32'(bus.mux_an_out), 32'h0);
    check("rel_bcd", 32'(bus.mux_bcd_out), 32'h0);

    exp_frame = 24'h0;
    prev_an   = 6'd0;
    mon_en    = 1'b1;
    for (int s = 0; s < N_SLOTS; s++) begin
      idx = s % 6;
      f   = s / 6;
      if (idx == 0 && s > 0) exp_frame = bus.mux_digits_in;
      if (idx == 0) begin
        case (f)
          3: begin
            bus.mux_digits_in     = 24'h012345;
            bus.mux_blank_lead_in = 1'b1;
          end
          4: bus.mux_digits_in = 24'h1ABCDE;
          5: begin
            bus.mux_digits_in     = 24'h123456;
            bus.mux_blink_mask_in = 6'b000011;
          end
          9: bus.mux_blink_mask_in = 6'b111111;
          default: ;
        endcase
      end
      if (f == 2 && idx == 2) bus.mux_digits_in = 24'h999999;
      push_slot(idx, f);
      repeat (SDIV) @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1 mon_en = 1'b0;
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    check("slots", 32'(n_popped), 32'(N_SLOTS));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_mux.md
DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per digit slot, minimum 2.
REQ-002 Parameter BLINK_FRAMES, default 83: scan frames per blink half-period, minimum 1.
REQ-003 mux_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 mux_rst  in  1  asynchronous, active-high reset.
REQ-005 mux_digits_in  in  24  six BCD nibbles: [3:0] seconds units, [7:4] seconds tens, [11:8] minutes units, [15:12] minutes tens, [19:16] hours units, [23:20] hours tens.
REQ-006 mux_blank_lead_in  in  1  blank hours-tens when it is zero.
REQ-007 mux_blink_mask_in  in  6  bit i set = digit i blinks (time-set mode).
REQ-008 mux_bcd_out  out  4  nibble driven to the shared BCD-to-7-segment decoder.
REQ-009 mux_seg_in  in  7  decoder result, combinational from mux_bcd_out, bit order g..a.
REQ-010 mux_seg_out  out  7  segments to the panel, active-high, bit order g..a.
REQ-011 mux_an_out  out  6  digit enables, one-hot or all-zero, active-high, bit i = digit i.
REQ-012 mux_dp_out  out  1  colon dot, driven on digits 2 and 4.

Function
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick = count at SCAN_DIV-1.
REQ-014 Digit index SHALL advance 0,1,..,5,0 on each tick.
REQ-015 On the tick that wraps index 5->0, frame register SHALL capture mux_digits_in; digits SHALL be taken only from the frame register (no tearing within a frame).
REQ-016 mux_bcd_out SHALL be registered, equal to frame nibble of the current index, updated on the same edge as the index.
REQ-017 Slot FSM states: GUARD, ON; tick -> GUARD; GUARD -> ON after exactly one cycle; ON holds until next tick.
REQ-018 In GUARD, mux_an_out SHALL be 000000 (anti-ghosting); in ON, mux_an_out SHALL be one-hot at the current index, registered.
REQ-019 mux_seg_out SHALL be combinational: 0 when blanked or state is GUARD, else mux_seg_in.
REQ-020 Blanked = (index 5, nibble 0, mux_blank_lead_in=1) OR (mask bit of index set, blink phase off).
REQ-021 Blink phase SHALL start on, toggle after every BLINK_FRAMES completed frames (frame counter wraps).
REQ-022 mux_dp_out SHALL be 1 only in ON with index 2 or 4 and blink phase on.
REQ-023 Non-BCD nibbles (10-15) SHALL pass through unchanged; decoder blanks them.
REQ-024 mux_blink_mask_in and mux_blank_lead_in SHALL act immediately (not frame-latched).

Reset
REQ-025 On mux_rst: prescaler 0, index 0, state GUARD, frame register 0, frame counter 0, blink phase on; mux_bcd_out 0, mux_an_out 000000, mux_seg_out 0, mux_dp_out 0.
REQ-026 Reset asserted mid-slot SHALL take effect without waiting for mux_clk; after release, first ON cycle is index 0 on second edge.

Configuration
REQ-027 Macro DISPLAY_MUX_BLINK_EN defined: blink counter, phase and mask behave per REQ-020..022.
REQ-028 Macro undefined: no blink logic; mask ignored; phase treated as constantly on (colon steady).

Structure
REQ-029 Package display_mux_pkg SHALL hold N_DIGITS=6, slot-state enum (GUARD, ON) and digit-index typedef.
REQ-030 Prescaler SHALL be a sub-module tick_div (parameter DIV, outputs tick); decoder stays external.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-031 Reset asserted mid-slot -> outputs all zero at once; after release, index 0, mux_an_out 000000 then 000001.
REQ-032 mux_digits_in=0x123456 -> mux_bcd_out 6,5,4,3,2,1 repeating, 4 cycles each; mux_an_out 0 for 1 cycle then one-hot 000001..100000.
REQ-033 Change mux_digits_in 0x123456 -> 0x999999 during index 2 -> indices 3..5 still show 3,2,1; 9s from next index 0.
REQ-034 Hours tens 0, mux_blank_lead_in=1 -> mux_seg_out 0 in index-5 slots; hours tens 1 -> mux_seg_out = mux_seg_in.
REQ-035 Mask 000011 -> digits 0,1 segments 0 in frames 3-4, 7-8, visible in frames 1-2, 5-6; mux_dp_out pulses at indices 2,4 only in visible frames.
REQ-036 Build without DISPLAY_MUX_BLINK_EN, mask 111111 -> all digits always visible, mux_dp_out high in every ON cycle of indices 2,4.
